// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port: stores push bytes
// into a TX FIFO, loads read status combinationally in the same cycle.
module dbus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [15:0]   baud_div_q;
  logic          tx_en_q, irq_en_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic        sel, wr_sel, push, push_ok, pop, full, empty, busy, ovf_clr;
  logic [1:0]  off;
  logic [15:0] div_eff, reload;
  logic [31:0] status;
  logic        unused_bits;

  assign sel     = (a[31:4] == BASE_ADDR[31:4]);
  assign off     = a[3:2];
  assign wr_sel  = we & sel;
  assign push    = wr_sel & (off == 2'd0) & be[0];
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign ovf_clr = wr_sel & (off == 2'd1) & be[0] & wd[3];
  assign busy    = (state_q != ST_IDLE);
  assign irq     = irq_en_q & empty & ~busy;

  assign div_eff = (baud_div_q == '0) ? 16'd1 : baud_div_q;
  assign reload  = div_eff - 16'd1;

  assign unused_bits = ^{a[1:0], be[3:2], wd[31:16]};

  assign status = {23'd0, 5'(count_q), overflow_q, busy, empty, full};

  always_comb begin
    rd = '0;
    if (sel) begin
      unique case (off)
        2'd0: rd = '0;
        2'd1: rd = status;
        2'd2: rd = {16'd0, baud_div_q};
        2'd3: rd = {30'd0, irq_en_q, tx_en_q};
      endcase
    end
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    tx        = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          timer_d = reload;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (timer_q == '0) begin
          timer_d   = reload;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (timer_q == '0) begin
          timer_d   = reload;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone decide
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_div_q <= DEFAULT_DIV;
      tx_en_q    <= 1'b1;
      irq_en_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A push that hits a full FIFO wins over a same-cycle clear.
      if (push && full) overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      if (wr_sel && off == 2'd2) begin
        if (be[0]) baud_div_q[7:0]  <= wd[7:0];
        if (be[1]) baud_div_q[15:8] <= wd[15:8];
      end
      if (wr_sel && off == 2'd3 && be[0]) begin
        tx_en_q  <= wd[0];
        irq_en_q <= wd[1];
      end
    end
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed self-checking bench for dbus_uart_tx with a 4-cycle default bit time.
module tb_dbus_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk, rst_n, we, tx, irq;
  logic [31:0] a, wd, rd;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;

  dbus_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(16'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .a    (a),
    .be   (be),
    .wd   (wd),
    .rd   (rd),
    .tx   (tx),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be_v, input logic [31:0] data);
    we = 1'b1; a = addr; be = be_v; wd = data;
    @(posedge clk);
    #1;
    we = 1'b0; a = '0; be = '0; wd = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
    a = '0;
  endtask

  // Waits for a falling tx, then samples every cycle of the 10 frame slots.
  // Slots below slot_change last div_a cycles, later ones div_b cycles.
  task automatic capture_frame(input int div_a, input int slot_change, input int div_b,
                               output logic [7:0] data, output logic good, output int waited);
    logic [9:0] v;
    logic       found;
    int         dur;
    good = 1'b1; data = '0; waited = 0; found = 1'b0; v = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        found  = 1'b1;
        waited = i;
        break;
      end
    end
    if (!found) begin
      good = 1'b0;
      return;
    end
    for (int k = 0; k < 10; k++) begin
      dur = (k < slot_change) ? div_a : div_b;
      for (int c = 0; c < dur; c++) begin
        if (!(k == 0 && c == 0)) begin
          @(posedge clk);
          #1;
        end
        if (c == 0) v[k] = tx;
        else if (tx !== v[k]) good = 1'b0;
      end
    end
    if (v[0] !== 1'b0 || v[9] !== 1'b1) good = 1'b0;
    data = v[8:1];
  endtask

  task automatic test_reset;
    logic [31:0] r;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(BASE + 32'h4, r);
    checks++;
    if (r !== 32'h002) begin errors++; $display("FAIL reset_status: got %h expected 002", r); end
    bus_read(BASE + 32'h8, r);
    checks++;
    if (r !== 32'h4) begin errors++; $display("FAIL reset_bauddiv: got %h expected 4", r); end
    bus_read(BASE + 32'hC, r);
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h expected 1", r); end
    bus_read(BASE, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_txdata_read: got %h expected 0", r); end
  endtask

  task automatic test_single_frame;
    logic [7:0]  d;
    logic        g;
    int          w;
    logic [31:0] st_mid, r;
    bus_write(BASE, 4'b0001, 32'h55);
    fork
      capture_frame(4, 10, 4, d, g, w);
      begin
        wait_cycles(20);
        bus_read(BASE + 32'h4, st_mid);
      end
    join
    checks++;
    if (w !== 1) begin errors++; $display("FAIL frame55_latency: got %0d expected 1", w); end
    checks++;
    if (!g || d !== 8'h55) begin errors++; $display("FAIL frame55_data: got %h ok=%b expected 55 ok=1", d, g); end
    checks++;
    if (st_mid !== 32'h006) begin errors++; $display("FAIL frame55_busy_status: got %h expected 006", st_mid); end
    wait_cycles(1);
    bus_read(BASE + 32'h4, r);
    checks++;
    if (r !== 32'h002) begin errors++; $display("FAIL frame55_status_after: got %h expected 002", r); end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    logic [7:0]  d;
    logic        g;
    int          w;
    bus_write(BASE + 32'hC, 4'b0001, 32'h0);
    for (int i = 0; i <= 16; i++) bus_write(BASE, 4'b0001, 32'(i));
    bus_read(BASE + 32'h4, r);
    checks++;
    if (r !== 32'h109) begin errors++; $display("FAIL ovf_status_full: got %h expected 109", r); end
    bus_write(BASE + 32'hC, 4'b0001, 32'h1);
    for (int i = 0; i < 16; i++) begin
      capture_frame(4, 10, 4, d, g, w);
      checks++;
      if (!g || d !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_frame_%0d: got %h ok=%b expected %h ok=1", i, d, g, 8'(i));
      end
    end
    wait_cycles(2);
    bus_read(BASE + 32'h4, r);
    checks++;
    if (r !== 32'h00A) begin errors++; $display("FAIL ovf_drained_status: got %h expected 00a", r); end
    bus_write(BASE + 32'h4, 4'b0001, 32'h8);
    bus_read(BASE + 32'h4, r);
    checks++;
    if (r !== 32'h002) begin errors++; $display("FAIL ovf_clear: got %h expected 002", r); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] r;
    logic [7:0]  d;
    logic        g;
    int          w;
    bus_write(BASE + 32'h1, 4'b0010, 32'h0000AA00);
    bus_read(BASE + 32'h4, r);
    checks++;
    if (r !== 32'h002) begin errors++; $display("FAIL lane1_no_push: got %h expected 002", r); end
    bus_write(BASE, 4'b0001, 32'h0000AAA5);
    capture_frame(4, 10, 4, d, g, w);
    checks++;
    if (!g || d !== 8'hA5) begin errors++; $display("FAIL lane0_frame: got %h ok=%b expected a5 ok=1", d, g); end
  endtask

  task automatic test_baud_change;
    logic [7:0]  d;
    logic        g;
    int          w;
    logic [31:0] r;
    wait_cycles(2);
    bus_write(BASE, 4'b0001, 32'h3C);
    fork
      capture_frame(4, 5, 8, d, g, w);
      begin
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(posedge clk);
          #1;
          if (tx === 1'b0) begin found = 1'b1; break; end
        end
        if (found) begin
          wait_cycles(17);
          bus_write(BASE + 32'h8, 4'b0011, 32'h8);
        end
      end
    join
    checks++;
    if (!g || d !== 8'h3C) begin errors++; $display("FAIL baud_change_frame: got %h ok=%b expected 3c ok=1", d, g); end
    bus_read(BASE + 32'h8, r);
    checks++;
    if (r !== 32'h8) begin errors++; $display("FAIL baud_readback: got %h expected 8", r); end
    wait_cycles(2);
    bus_write(BASE + 32'h8, 4'b0011, 32'h4);
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] r;
    logic        found, low_seen;
    bus_write(BASE + 32'h8, 4'b0011, 32'h6);
    bus_write(BASE, 4'b0001, 32'h11);
    bus_write(BASE, 4'b0001, 32'h22);
    bus_write(BASE, 4'b0001, 32'h33);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx === 1'b0) begin found = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_frame_start: got no start bit expected one"); end
    wait_cycles(20);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx_immediate: got %b expected 1", tx); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_cycles(1);
    bus_read(BASE + 32'h4, r);
    checks++;
    if (r !== 32'h002) begin errors++; $display("FAIL rst_status: got %h expected 002", r); end
    bus_read(BASE + 32'h8, r);
    checks++;
    if (r !== 32'h4) begin errors++; $display("FAIL rst_bauddiv: got %h expected 4", r); end
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    checks++;
    if (low_seen) begin errors++; $display("FAIL rst_no_frame: got tx activity expected idle line"); end
  endtask

  task automatic test_irq;
    logic [31:0] r;
    int          first_k;
    bus_write(BASE + 32'hC, 4'b0001, 32'h3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle_empty: got %b expected 1", irq); end
    bus_write(BASE, 4'b0001, 32'h81);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_push: got %b expected 0", irq); end
    bus_write(BASE, 4'b0001, 32'h7E);
    first_k = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (irq === 1'b1) begin first_k = k; break; end
    end
    checks++;
    if (first_k != 81) begin errors++; $display("FAIL irq_rise_cycle: got %0d expected 81", first_k); end
    bus_read(BASE + 32'h20, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL unselected_read: got %h expected 0", r); end
    bus_write(BASE + 32'hC, 4'b0001, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b expected 0", irq); end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; a = '0; be = '0; wd = '0;
    #12;
    rst_n = 1'b1;
    wait_cycles(1);
    test_reset;
    test_single_frame;
    test_overflow;
    test_byte_lanes;
    test_baud_change;
    test_reset_mid_frame;
    test_irq;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
